// File: rtl/regfile_write_arbiter_pkg.sv
// Shared constants and types for the register file write-port arbiter.
package regfile_write_arbiter_pkg;

    localparam int DEF_DATA_WIDTH     = 32;
    localparam int DEF_REG_ADDR_WIDTH = 5;
    localparam int DEF_CNT_WIDTH      = 16;
    localparam int ZERO_REG           = 0;

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_M = 1'b1
    } port_sel_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits: set on reserve, cleared on commit, two read ports.
// Set wins over clear on the same register; register 0 never becomes busy.
module regfile_scoreboard
    import regfile_write_arbiter_pkg::*;
#(
    parameter int REG_ADDR_WIDTH = DEF_REG_ADDR_WIDTH
) (
    input  logic                      Clock,
    input  logic                      Reset,
    input  logic                      set_vld,
    input  logic [REG_ADDR_WIDTH-1:0] set_id,
    input  logic                      clr_vld,
    input  logic [REG_ADDR_WIDTH-1:0] clr_id,
    input  logic [REG_ADDR_WIDTH-1:0] query_a_id,
    input  logic [REG_ADDR_WIDTH-1:0] query_b_id,
    output logic                      busy_a,
    output logic                      busy_b
);

    localparam int NUM_REGS = 2 ** REG_ADDR_WIDTH;

    logic [NUM_REGS-1:0] busy;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            busy <= '0;
        end else begin
            if (clr_vld) begin
                busy[clr_id] <= 1'b0;
            end
            // Ordered after the clear so a same-edge reserve keeps the bit set.
            if (set_vld && (set_id != REG_ADDR_WIDTH'(ZERO_REG))) begin
                busy[set_id] <= 1'b1;
            end
        end
    end

    assign busy_a = busy[query_a_id];
    assign busy_b = busy[query_b_id];

endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing one register file write port between ALU and load
// writeback, with a registered write interface and a RAW busy scoreboard.
module regfile_write_arbiter
    import regfile_write_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int REG_ADDR_WIDTH = DEF_REG_ADDR_WIDTH,
    parameter int CNT_WIDTH      = DEF_CNT_WIDTH
) (
    input  logic                      Clock,
    input  logic                      Reset,
    input  logic                      AValid,
    input  logic [REG_ADDR_WIDTH-1:0] ARegID,
    input  logic [DATA_WIDTH-1:0]     AData,
    output logic                      AReady,
    input  logic                      MValid,
    input  logic [REG_ADDR_WIDTH-1:0] MRegID,
    input  logic [DATA_WIDTH-1:0]     MData,
    output logic                      MReady,
    input  logic                      ReserveValid,
    input  logic [REG_ADDR_WIDTH-1:0] ReserveID,
    input  logic [REG_ADDR_WIDTH-1:0] QueryAID,
    input  logic [REG_ADDR_WIDTH-1:0] QueryBID,
    output logic                      BusyA,
    output logic                      BusyB,
    output logic                      WriteEnable,
    output logic [REG_ADDR_WIDTH-1:0] WriteRegID,
    output logic [DATA_WIDTH-1:0]     WriteData,
    output logic [CNT_WIDTH-1:0]      ConflictCount
);

    port_sel_t                 last_grant;
    logic                      tie;
    logic                      xfer;
    logic [REG_ADDR_WIDTH-1:0] xfer_id;
    logic [DATA_WIDTH-1:0]     xfer_data;

    // On a tie the port that did not win the previous tie gets the grant.
    assign tie    = AValid && MValid;
    assign AReady = AValid && (!MValid || (last_grant == PORT_M));
    assign MReady = MValid && (!AValid || (last_grant == PORT_A));

    assign xfer      = AReady || MReady;
    assign xfer_id   = AReady ? ARegID : MRegID;
    assign xfer_data = AReady ? AData  : MData;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            last_grant <= PORT_M;
        end else if (tie) begin
            last_grant <= AReady ? PORT_A : PORT_M;
        end
    end

    // Writes to register 0 are accepted but never reach the register file.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            WriteEnable <= 1'b0;
            WriteRegID  <= '0;
            WriteData   <= '0;
        end else begin
            WriteEnable <= xfer && (xfer_id != REG_ADDR_WIDTH'(ZERO_REG));
            if (xfer) begin
                WriteRegID <= xfer_id;
                WriteData  <= xfer_data;
            end
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            ConflictCount <= '0;
        end else if (tie && (ConflictCount != {CNT_WIDTH{1'b1}})) begin
            ConflictCount <= ConflictCount + CNT_WIDTH'(1);
        end
    end

    regfile_scoreboard #(
        .REG_ADDR_WIDTH(REG_ADDR_WIDTH)
    ) u_scoreboard (
        .Clock      (Clock),
        .Reset      (Reset),
        .set_vld    (ReserveValid),
        .set_id     (ReserveID),
        .clr_vld    (WriteEnable),
        .clr_id     (WriteRegID),
        .query_a_id (QueryAID),
        .query_b_id (QueryBID),
        .busy_a     (BusyA),
        .busy_b     (BusyB)
    );

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench: directed vector table, hand sequences, and random traffic
// against a behavioural model of the arbiter and scoreboard.
module tb_regfile_write_arbiter;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic        AValid = 1'b0, MValid = 1'b0, ReserveValid = 1'b0;
    logic [4:0]  ARegID = '0, MRegID = '0, ReserveID = '0, QueryAID = '0, QueryBID = '0;
    logic [31:0] AData = '0, MData = '0;
    logic        AReady, MReady, BusyA, BusyB, WriteEnable;
    logic [4:0]  WriteRegID;
    logic [31:0] WriteData;
    logic [15:0] ConflictCount;

    int errors = 0;
    int checks = 0;

    regfile_write_arbiter dut (
        .Clock(Clock), .Reset(Reset),
        .AValid(AValid), .ARegID(ARegID), .AData(AData), .AReady(AReady),
        .MValid(MValid), .MRegID(MRegID), .MData(MData), .MReady(MReady),
        .ReserveValid(ReserveValid), .ReserveID(ReserveID),
        .QueryAID(QueryAID), .QueryBID(QueryBID), .BusyA(BusyA), .BusyB(BusyB),
        .WriteEnable(WriteEnable), .WriteRegID(WriteRegID), .WriteData(WriteData),
        .ConflictCount(ConflictCount)
    );

    always #5 Clock = ~Clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic idle_inputs();
        AValid = 1'b0; MValid = 1'b0; ReserveValid = 1'b0;
        ARegID = '0; MRegID = '0; ReserveID = '0; QueryAID = '0; QueryBID = '0;
        AData = '0; MData = '0;
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        idle_inputs();
        tick();
        tick();
        Reset = 1'b0;
    endtask

    typedef struct {
        logic        av;
        logic [4:0]  aid;
        logic [31:0] adat;
        logic        mv;
        logic [4:0]  mid;
        logic [31:0] mdat;
        logic        ear, emr, ewe, chkw;
        logic [4:0]  ewid;
        logic [31:0] ewdat;
        logic [15:0] ecnt;
    } vec_t;

    vec_t tbl[13];

    task automatic set_row(input int i, input int av, input int aid, input int adat,
                           input int mv, input int mid, input int mdat,
                           input int ear, input int emr, input int ewe, input int chkw,
                           input int ewid, input int ewdat, input int ecnt);
        tbl[i].av = 1'(av);   tbl[i].aid = 5'(aid); tbl[i].adat = 32'(adat);
        tbl[i].mv = 1'(mv);   tbl[i].mid = 5'(mid); tbl[i].mdat = 32'(mdat);
        tbl[i].ear = 1'(ear); tbl[i].emr = 1'(emr); tbl[i].ewe = 1'(ewe);
        tbl[i].chkw = 1'(chkw); tbl[i].ewid = 5'(ewid); tbl[i].ewdat = 32'(ewdat);
        tbl[i].ecnt = 16'(ecnt);
    endtask

    // Behavioural model state
    bit        m_we;
    bit [4:0]  m_wid;
    bit [31:0] m_wdat;
    bit        m_busy[32];
    int        m_cnt;
    bit        m_a_wins_tie;

    task automatic model_reset();
        m_we = 0; m_wid = 0; m_wdat = 0; m_cnt = 0; m_a_wins_tie = 1;
        foreach (m_busy[i]) m_busy[i] = 0;
    endtask

    initial begin
        bit a_pend, m_pend, exp_ar, exp_mr;

        // Directed vectors from reset: single writes, 4-cycle conflict, register 0 write
        set_row(0,  1,5,'hAA, 0,0,0,      1,0, 0,1,0,0,    0);
        set_row(1,  0,0,0,    0,0,0,      0,0, 1,1,5,'hAA, 0);
        set_row(2,  0,0,0,    0,0,0,      0,0, 0,1,5,'hAA, 0);
        set_row(3,  1,3,'h11, 1,4,'h22,   1,0, 0,1,5,'hAA, 0);
        set_row(4,  1,3,'h11, 1,4,'h22,   0,1, 1,1,3,'h11, 1);
        set_row(5,  1,3,'h11, 1,4,'h22,   1,0, 1,1,4,'h22, 2);
        set_row(6,  1,3,'h11, 1,4,'h22,   0,1, 1,1,3,'h11, 3);
        set_row(7,  0,0,0,    0,0,0,      0,0, 1,1,4,'h22, 4);
        set_row(8,  0,0,0,    1,9,'h33,   0,1, 0,1,4,'h22, 4);
        set_row(9,  1,0,'h44, 0,0,0,      1,0, 1,1,9,'h33, 4);
        set_row(10, 0,0,0,    0,0,0,      0,0, 0,0,0,0,    4);
        set_row(11, 1,1,'h55, 1,2,'h66,   1,0, 0,0,0,0,    4);
        set_row(12, 0,0,0,    0,0,0,      0,0, 1,1,1,'h55, 5);

        #1;
        check("reset_we", WriteEnable, 1'b0);
        check("reset_cnt", ConflictCount, 16'h0);
        do_reset();

        for (int i = 0; i < 13; i++) begin
            AValid = tbl[i].av; ARegID = tbl[i].aid; AData = tbl[i].adat;
            MValid = tbl[i].mv; MRegID = tbl[i].mid; MData = tbl[i].mdat;
            #2;
            check($sformatf("vec%0d_aready", i), AReady, tbl[i].ear);
            check($sformatf("vec%0d_mready", i), MReady, tbl[i].emr);
            check($sformatf("vec%0d_we", i), WriteEnable, tbl[i].ewe);
            if (tbl[i].chkw) begin
                check($sformatf("vec%0d_wid", i), WriteRegID, tbl[i].ewid);
                check($sformatf("vec%0d_wdat", i), WriteData, tbl[i].ewdat);
            end
            check($sformatf("vec%0d_cnt", i), ConflictCount, tbl[i].ecnt);
            if (i != 12) tick();
        end

        // Async reset mid-cycle while a write is pending and a register is busy
        tick();
        ReserveValid = 1'b1; ReserveID = 5'd12;
        AValid = 1'b1; ARegID = 5'd8; AData = 32'h88;
        tick();
        idle_inputs();
        QueryAID = 5'd12;
        #2;
        check("pre_rst_we", WriteEnable, 1'b1);
        check("pre_rst_busy", BusyA, 1'b1);
        #1 Reset = 1'b1;
        #1;
        check("async_rst_we", WriteEnable, 1'b0);
        check("async_rst_busy", BusyA, 1'b0);
        check("async_rst_cnt", ConflictCount, 16'h0);
        tick();
        Reset = 1'b0;
        idle_inputs();

        // Reserve 7, commit via M, then same-edge reserve+clear of 7
        ReserveValid = 1'b1; ReserveID = 5'd7;
        tick();
        ReserveValid = 1'b0;
        QueryAID = 5'd7;
        MValid = 1'b1; MRegID = 5'd7; MData = 32'h77;
        #2;
        check("sb_busy_set", BusyA, 1'b1);
        check("sb_mready", MReady, 1'b1);
        tick();
        MValid = 1'b0;
        #2;
        check("sb_commit_we", WriteEnable, 1'b1);
        check("sb_busy_until_commit", BusyA, 1'b1);
        tick();
        #2;
        check("sb_busy_cleared", BusyA, 1'b0);
        MValid = 1'b1; MRegID = 5'd7; MData = 32'h78;
        tick();
        MValid = 1'b0;
        ReserveValid = 1'b1; ReserveID = 5'd7;
        #2;
        check("sb_same_edge_we", WriteEnable, 1'b1);
        tick();
        ReserveValid = 1'b0;
        #2;
        check("sb_set_wins", BusyA, 1'b1);

        // Register 0: accepted, no write enable, never busy
        tick();
        AValid = 1'b1; ARegID = 5'd0; AData = 32'h99;
        ReserveValid = 1'b1; ReserveID = 5'd0; QueryAID = 5'd0;
        #2;
        check("r0_aready", AReady, 1'b1);
        tick();
        idle_inputs();
        #2;
        check("r0_we", WriteEnable, 1'b0);
        check("r0_busy", BusyA, 1'b0);

        // Random traffic against the model
        do_reset();
        model_reset();
        a_pend = 0; m_pend = 0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            if (!a_pend && $urandom_range(0, 2) != 0) begin
                a_pend = 1; ARegID = 5'($urandom_range(0, 31)); AData = $urandom;
            end
            if (!m_pend && $urandom_range(0, 2) != 0) begin
                m_pend = 1; MRegID = 5'($urandom_range(0, 31)); MData = $urandom;
            end
            AValid = a_pend;
            MValid = m_pend;
            ReserveValid = ($urandom_range(0, 3) == 0);
            ReserveID = 5'($urandom_range(0, 31));
            QueryAID = 5'($urandom_range(0, 31));
            QueryBID = ($urandom_range(0, 1) == 0) ? m_wid : 5'($urandom_range(0, 31));
            #2;
            exp_ar = a_pend && (!m_pend || m_a_wins_tie);
            exp_mr = m_pend && !exp_ar;
            check("rnd_aready", AReady, exp_ar);
            check("rnd_mready", MReady, exp_mr);
            check("rnd_we", WriteEnable, m_we);
            if (m_we) begin
                check("rnd_wid", WriteRegID, m_wid);
                check("rnd_wdat", WriteData, m_wdat);
            end
            check("rnd_busya", BusyA, m_busy[QueryAID]);
            check("rnd_busyb", BusyB, m_busy[QueryBID]);
            check("rnd_cnt", ConflictCount, 16'(m_cnt));
            tick();
            if (a_pend && m_pend) begin
                m_a_wins_tie = !exp_ar;
                if (m_cnt < 65535) m_cnt++;
            end
            if (m_we) m_busy[m_wid] = 0;
            if (ReserveValid && ReserveID != 0) m_busy[ReserveID] = 1;
            if (exp_ar || exp_mr) begin
                m_wid  = exp_ar ? ARegID : MRegID;
                m_wdat = exp_ar ? AData : MData;
                m_we   = (m_wid != 0);
            end else begin
                m_we = 0;
            end
            if (exp_ar) a_pend = 0;
            if (exp_mr) m_pend = 0;
        end

        // Counter saturation
        do_reset();
        AValid = 1'b1; ARegID = 5'd1; MValid = 1'b1; MRegID = 5'd2;
        repeat (65534) tick();
        #2;
        check("sat_fffe", ConflictCount, 16'hFFFE);
        repeat (5) tick();
        #2;
        check("sat_hold", ConflictCount, 16'hFFFF);
        check("sat_never_both", AReady & MReady, 1'b0);
        idle_inputs();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Shares the register file's single write port between two writeback requesters: ALU result (port A) and memory load (port M).
- Round-robin arbitration with a valid/ready handshake; the winning write is registered onto the register file write interface.
- Holds a per-register busy scoreboard, set by the issue stage and cleared on write commit, so the issue stage can stall on read-after-write hazards.
- Sits between the execute/memory stages and the register file write inputs (data, write register ID, write enable).

Parameters:
- DATA_WIDTH, 32, width of write data.
- REG_ADDR_WIDTH, 5, register ID width; number of registers is 2**REG_ADDR_WIDTH.
- CNT_WIDTH, 16, width of the saturating conflict counter.

Ports:
- Clock  input  1  single clock; all state updates on the rising edge.
- Reset  input  1  asynchronous, active-high reset.
- AValid  input  1  ALU writeback request.
- ARegID  input  REG_ADDR_WIDTH  ALU destination register.
- AData  input  DATA_WIDTH  ALU result.
- AReady  output  1  ALU request granted this cycle (combinational).
- MValid  input  1  memory writeback request.
- MRegID  input  REG_ADDR_WIDTH  memory destination register.
- MData  input  DATA_WIDTH  load data.
- MReady  output  1  memory request granted this cycle (combinational).
- ReserveValid  input  1  issue stage reserves a destination register.
- ReserveID  input  REG_ADDR_WIDTH  register to mark busy.
- QueryAID  input  REG_ADDR_WIDTH  first source register of the issuing instruction.
- QueryBID  input  REG_ADDR_WIDTH  second source register.
- BusyA  output  1  QueryAID has a pending write (combinational).
- BusyB  output  1  QueryBID has a pending write (combinational).
- WriteEnable  output  1  to register file write enable (registered).
- WriteRegID  output  REG_ADDR_WIDTH  to register file write register ID (registered).
- WriteData  output  DATA_WIDTH  to register file write data (registered).
- ConflictCount  output  CNT_WIDTH  cycles in which a valid request was denied (saturating).

Behaviour:
- Interface: one clock; reset is asynchronous and active-high. Ports are named Clock and Reset.
- Reset values:
  - WriteEnable=0, WriteRegID=0, WriteData=0.
  - All busy bits=0; ConflictCount=0.
  - Priority pointer LastGrant=M, so A wins the first tie.
- Arbitration (combinational, per cycle):
  - Only AValid: AReady=1.
  - Only MValid: MReady=1.
  - Both valid: grant the port that is not LastGrant; the other port's Ready=0.
  - LastGrant updates to the granted port only on a tie.
  - AReady and MReady are never both 1.
- Requester rule: a requester holds Valid, RegID and Data stable until it sees Ready=1. Transfer occurs on the cycle where Valid&&Ready.
- Latency:
  - A transfer in cycle N drives WriteEnable/WriteRegID/WriteData in cycle N+1.
  - The register file captures at the edge ending N+1.
  - With no transfer, WriteEnable=0 next cycle; WriteRegID and WriteData hold their previous values.
- Register 0:
  - A transfer to ID 0 is accepted (Ready=1) but produces WriteEnable=0.
  - A reserve of ID 0 is ignored; busy[0] is always 0.
- Scoreboard:
  - busy[ReserveID] is set at the edge when ReserveValid=1.
  - busy[WriteRegID] is cleared at the edge when WriteEnable=1, i.e. at the same edge the register file commits.
  - Reserve and clear of the same ID at the same edge: set wins.
  - Reserve of an ID that is already busy: stays busy. Only one outstanding write per register is tracked; the issue stage guarantees this.
  - BusyA=busy[QueryAID], BusyB=busy[QueryBID], read from current state (no bypass of same-cycle reserve/clear).
- ConflictCount increments by 1 each cycle that both ports are valid; it saturates at all-ones and never wraps.
- Reset mid-operation:
  - Any pending registered write is dropped (WriteEnable forced 0 immediately).
  - Scoreboard is cleared.
  - Ungranted requests have no retained state.

Decomposition:
- Shared package: DATA_WIDTH/REG_ADDR_WIDTH defaults, a zero-register constant, and a two-value port-select enum (PORT_A, PORT_M) used for LastGrant.
- One natural sub-module: regfile_scoreboard (busy-bit array with set/clear/two query ports). Arbitration, output registers and counter stay in the top module.

Test Plan:
- Reset asserted asynchronously mid-cycle with WriteEnable=1 -> WriteEnable, busy bits, ConflictCount are 0 immediately, without waiting for a clock edge.
- AValid=1, ARegID=5, AData=0x0000_00AA alone at cycle N -> AReady=1 in N; WriteEnable=1, WriteRegID=5, WriteData=0xAA in N+1; WriteEnable=0 in N+2.
- AValid and MValid held for 4 cycles (ARegID=3, MRegID=4) -> grants A, M, A, M; ConflictCount=4 afterwards; never both Ready.
- ReserveValid with ReserveID=7, then M writes reg 7 -> BusyA=1 with QueryAID=7 until the WriteEnable commit edge; BusyA=0 the cycle after; same-edge reserve+clear of 7 leaves BusyA=1.
- AValid with ARegID=0 and ReserveID=0 -> AReady=1, WriteEnable stays 0, and BusyA with QueryAID=0 stays 0.
- Force 2**CNT_WIDTH+3 conflict cycles -> ConflictCount holds at all-ones (0xFFFF).
